// File: rtl/udp_frame_rx_filter.sv
// Eth/IPv4/UDP receive filter: parses headers from an 8-bit AXI-Stream and matches them against the
// configured addresses. In-range payloads are streamed to the accelerator buffer with commit/drop events.
module udp_frame_rx_filter #(
  parameter int PAYLOAD_MIN_BYTES = 785,
  parameter int PAYLOAD_MAX_BYTES = 785,
  parameter int ADDR_WIDTH        = 10,
  parameter bit CHECK_MAC         = 1'b1,
  parameter bit CHECK_UDP_PORT    = 1'b1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [31:0]           ACCEL_IP,
  input  logic [47:0]           ACCEL_MAC,
  input  logic [15:0]           ACCEL_UDP_PORT,
  input  logic [7:0]            S_TDATA,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic                  S_TLAST,
  input  logic                  S_TUSER,
  output logic [7:0]            RX_DATA,
  output logic [ADDR_WIDTH-1:0] RX_ADDR,
  output logic                  RX_EN,
  output logic                  FRAME_READY,
  output logic                  FRAME_DROP,
  output logic [ADDR_WIDTH:0]   FRAME_LEN,
  output logic [47:0]           SRC_MAC,
  output logic [31:0]           SRC_IP,
  output logic [15:0]           SRC_UDP_PORT,
  output logic [CNT_WIDTH-1:0]  ACCEPT_COUNT,
  output logic [CNT_WIDTH-1:0]  HDR_DROP_COUNT,
  output logic [CNT_WIDTH-1:0]  LEN_DROP_COUNT,
  output logic [CNT_WIDTH-1:0]  FCS_DROP_COUNT
);

  // The byte counter must hold both the 20-byte IP header index and a payload index of MAX.
  localparam int CW = (ADDR_WIDTH + 1 > 6) ? ADDR_WIDTH + 1 : 6;
  localparam logic [CW-1:0] MIN_C    = CW'(PAYLOAD_MIN_BYTES);
  localparam logic [CW-1:0] MAX_C    = CW'(PAYLOAD_MAX_BYTES);
  localparam logic [CW-1:0] ETH_LAST = CW'(13);
  localparam logic [CW-1:0] IP_LAST  = CW'(19);
  localparam logic [CW-1:0] UDP_LAST = CW'(7);

  typedef enum logic [2:0] {
    S_ETH, S_IP, S_UDP, S_PAYLOAD, S_COMMIT, S_DISCARD
  } state_t;

  state_t          state, state_nxt, hdr_next;
  logic [CW-1:0]   cnt, cnt_nxt, pay_len;
  logic            beat, hdr_last, hdr_ok;
  logic            eth_ok, ip_ok, udp_ok;
  logic            hdr_drop, len_drop, fcs_drop, commit;
  logic            drop_p1;

  logic [47:0]     dst_mac, src_mac;
  logic [7:0]      etype_hi, ip_ver, ip_proto;
  logic [31:0]     src_ip;
  logic [23:0]     dst_ip_hi;
  logic [15:0]     src_port, dst_port;

  logic [CNT_WIDTH-1:0] acc_cnt, hdr_cnt, len_cnt, fcs_cnt;
  logic [ADDR_WIDTH:0]  frame_len;
  logic [47:0]          src_mac_q;
  logic [31:0]          src_ip_q;
  logic [15:0]          src_port_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign S_TREADY = (state != S_COMMIT);
  assign beat     = S_TVALID & S_TREADY;
  assign pay_len  = cnt + 1'b1;

  // Checks fold in the byte currently on the bus, which is the last byte of its header.
  assign eth_ok = ({etype_hi, S_TDATA} == 16'h0800) &&
                  (!CHECK_MAC || (dst_mac == ACCEL_MAC) || (dst_mac == 48'hFFFF_FFFF_FFFF));
  assign ip_ok  = (ip_ver == 8'h45) && (ip_proto == 8'd17) && ({dst_ip_hi, S_TDATA} == ACCEL_IP);
  assign udp_ok = !CHECK_UDP_PORT || (dst_port == ACCEL_UDP_PORT);

  always_comb begin
    hdr_last = 1'b0;
    hdr_ok   = 1'b1;
    hdr_next = S_ETH;
    case (state)
      S_ETH: begin hdr_last = (cnt == ETH_LAST); hdr_ok = eth_ok; hdr_next = S_IP;      end
      S_IP:  begin hdr_last = (cnt == IP_LAST);  hdr_ok = ip_ok;  hdr_next = S_UDP;     end
      S_UDP: begin hdr_last = (cnt == UDP_LAST); hdr_ok = udp_ok; hdr_next = S_PAYLOAD; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hdr_drop  = 1'b0;
    len_drop  = 1'b0;
    fcs_drop  = 1'b0;
    commit    = 1'b0;
    case (state)
      S_ETH, S_IP, S_UDP: begin
        if (beat) begin
          if (S_TLAST) begin
            hdr_drop  = 1'b1;
            state_nxt = S_ETH;
            cnt_nxt   = '0;
          end else if (hdr_last) begin
            cnt_nxt = '0;
            if (hdr_ok) begin
              state_nxt = hdr_next;
            end else begin
              hdr_drop  = 1'b1;
              state_nxt = S_DISCARD;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (beat) begin
          if (cnt == MAX_C) begin
            len_drop  = 1'b1;
            state_nxt = S_TLAST ? S_ETH : S_DISCARD;
            cnt_nxt   = '0;
          end else if (S_TLAST) begin
            cnt_nxt = '0;
            if (pay_len < MIN_C) begin
              len_drop  = 1'b1;
              state_nxt = S_ETH;
            end else if (S_TUSER) begin
              fcs_drop  = 1'b1;
              state_nxt = S_ETH;
            end else begin
              commit    = 1'b1;
              state_nxt = S_COMMIT;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_COMMIT: begin
        state_nxt = S_ETH;
        cnt_nxt   = '0;
      end
      S_DISCARD: begin
        if (beat && S_TLAST) begin
          state_nxt = S_ETH;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_ETH;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage p0 -> p1: state, statistics and committed-frame metadata.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_ETH;
      cnt        <= '0;
      drop_p1    <= 1'b0;
      acc_cnt    <= '0;
      hdr_cnt    <= '0;
      len_cnt    <= '0;
      fcs_cnt    <= '0;
      frame_len  <= '0;
      src_mac_q  <= '0;
      src_ip_q   <= '0;
      src_port_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      drop_p1 <= hdr_drop | len_drop | fcs_drop;
      if (hdr_drop) hdr_cnt <= sat_inc(hdr_cnt);
      if (len_drop) len_cnt <= sat_inc(len_cnt);
      if (fcs_drop) fcs_cnt <= sat_inc(fcs_cnt);
      // Metadata is latched with the TLAST beat so it is already valid during FRAME_READY.
      if (commit) begin
        acc_cnt    <= sat_inc(acc_cnt);
        frame_len  <= pay_len[ADDR_WIDTH:0];
        src_mac_q  <= src_mac;
        src_ip_q   <= src_ip;
        src_port_q <= src_port;
      end
    end
  end

  // Header field capture; these registers are pure data and need no reset.
  always_ff @(posedge ACLK) begin
    if (beat) begin
      case (state)
        S_ETH: begin
          if (cnt < CW'(6))       dst_mac  <= {dst_mac[39:0], S_TDATA};
          else if (cnt < CW'(12)) src_mac  <= {src_mac[39:0], S_TDATA};
          else if (cnt == CW'(12)) etype_hi <= S_TDATA;
        end
        S_IP: begin
          if (cnt == CW'(0)) ip_ver <= S_TDATA;
          if (cnt == CW'(9)) ip_proto <= S_TDATA;
          if (cnt >= CW'(12) && cnt < CW'(16)) src_ip <= {src_ip[23:0], S_TDATA};
          if (cnt >= CW'(16) && cnt < CW'(19)) dst_ip_hi <= {dst_ip_hi[15:0], S_TDATA};
        end
        S_UDP: begin
          if (cnt < CW'(2))       src_port <= {src_port[7:0], S_TDATA};
          else if (cnt < CW'(4))  dst_port <= {dst_port[7:0], S_TDATA};
        end
        default: ;
      endcase
    end
  end

  assign RX_EN          = (state == S_PAYLOAD) && beat && (cnt != MAX_C);
  assign RX_ADDR        = cnt[ADDR_WIDTH-1:0];
  assign RX_DATA        = S_TDATA;
  assign FRAME_READY    = (state == S_COMMIT);
  assign FRAME_DROP     = drop_p1;
  assign FRAME_LEN      = frame_len;
  assign SRC_MAC        = src_mac_q;
  assign SRC_IP         = src_ip_q;
  assign SRC_UDP_PORT   = src_port_q;
  assign ACCEPT_COUNT   = acc_cnt;
  assign HDR_DROP_COUNT = hdr_cnt;
  assign LEN_DROP_COUNT = len_cnt;
  assign FCS_DROP_COUNT = fcs_cnt;

endmodule

// File: tb/tb_udp_frame_rx_filter.sv
// Bench for udp_frame_rx_filter: frames are scored by a byte-array reference model; a monitor
// pops expected writes/commit/drop events from a queue as the DUT produces them.
`timescale 1ns/1ps
module tb_udp_frame_rx_filter;
  localparam int MIN_B = 64;
  localparam int MAX_B = 785;
  localparam int AW    = 10;
  localparam int CNTW  = 16;
  localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] MY_IP   = 32'hC0A8_0A07;
  localparam logic [15:0] MY_PORT = 16'd5005;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [7:0]      S_TDATA = '0;
  logic            S_TVALID = 1'b0, S_TLAST = 1'b0, S_TUSER = 1'b0;
  logic            S_TREADY;
  logic [7:0]      RX_DATA;
  logic [AW-1:0]   RX_ADDR;
  logic            RX_EN, FRAME_READY, FRAME_DROP;
  logic [AW:0]     FRAME_LEN;
  logic [47:0]     SRC_MAC;
  logic [31:0]     SRC_IP;
  logic [15:0]     SRC_UDP_PORT;
  logic [CNTW-1:0] ACCEPT_COUNT, HDR_DROP_COUNT, LEN_DROP_COUNT, FCS_DROP_COUNT;

  always #5 ACLK = ~ACLK;

  udp_frame_rx_filter #(
    .PAYLOAD_MIN_BYTES(MIN_B), .PAYLOAD_MAX_BYTES(MAX_B), .ADDR_WIDTH(AW),
    .CHECK_MAC(1'b1), .CHECK_UDP_PORT(1'b1), .CNT_WIDTH(CNTW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ACCEL_IP(MY_IP), .ACCEL_MAC(MY_MAC), .ACCEL_UDP_PORT(MY_PORT),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .S_TLAST(S_TLAST), .S_TUSER(S_TUSER),
    .RX_DATA(RX_DATA), .RX_ADDR(RX_ADDR), .RX_EN(RX_EN),
    .FRAME_READY(FRAME_READY), .FRAME_DROP(FRAME_DROP), .FRAME_LEN(FRAME_LEN),
    .SRC_MAC(SRC_MAC), .SRC_IP(SRC_IP), .SRC_UDP_PORT(SRC_UDP_PORT),
    .ACCEPT_COUNT(ACCEPT_COUNT), .HDR_DROP_COUNT(HDR_DROP_COUNT),
    .LEN_DROP_COUNT(LEN_DROP_COUNT), .FCS_DROP_COUNT(FCS_DROP_COUNT)
  );

  localparam int EV_WR = 0, EV_READY = 1, EV_DROP = 2;
  typedef struct {
    int          kind;
    int          addr;
    logic [7:0]  data;
    int          len;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frm[$];
  int n_checks = 0, n_fail = 0;
  int exp_acc = 0, exp_hdr = 0, exp_len = 0, exp_fcs = 0;

  logic [47:0] f_dmac, f_smac;
  logic [15:0] f_etype, f_sport, f_dport;
  logic [7:0]  f_b0, f_proto;
  logic [31:0] f_sip, f_dip;
  int          f_plen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every DUT event must match the head of the expected queue.
  always @(negedge ACLK) begin : monitor
    ev_t e;
    int  kind;
    if (!ARESET && (RX_EN || FRAME_READY || FRAME_DROP)) begin
      kind = RX_EN ? EV_WR : (FRAME_READY ? EV_READY : EV_DROP);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_event: kind %0d seen, none expected (t=%0t)", kind, $time);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 64'(kind), 64'(e.kind));
        if (kind == EV_WR && e.kind == EV_WR) begin
          check("wr_addr", 64'(RX_ADDR), 64'(e.addr));
          check("wr_data", 64'(RX_DATA), 64'(e.data));
        end
        if (kind == EV_READY && e.kind == EV_READY) begin
          check("frame_len", 64'(FRAME_LEN), 64'(e.len));
          check("src_mac", 64'(SRC_MAC), 64'(e.mac));
          check("src_ip", 64'(SRC_IP), 64'(e.ip));
          check("src_port", 64'(SRC_UDP_PORT), 64'(e.port));
        end
      end
    end
  end

  function automatic logic [47:0] field(input int s, input int nb);
    logic [47:0] v = '0;
    for (int i = 0; i < nb; i++) v = {v[39:0], frm[s+i]};
    return v;
  endfunction

  task automatic push_ev(input int kind, input int addr, input logic [7:0] data, input int len,
                         input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.len = len;
    e.mac = mac; e.ip = ip; e.port = port;
    exp_q.push_back(e);
  endtask

  // Reference model: decides the fate of the whole frame from its bytes.
  task automatic model_frame(input bit tuser);
    int  n, p, nw;
    bit  hdr_ok;
    n = frm.size();
    if (n <= 42) begin
      exp_hdr++;
      push_ev(EV_DROP, 0, 8'h0, 0, '0, '0, '0);
      return;
    end
    hdr_ok = (field(12, 2) == 48'h0800) &&
             (field(0, 6) == MY_MAC || field(0, 6) == 48'hFFFF_FFFF_FFFF) &&
             (frm[14] == 8'h45) && (frm[23] == 8'd17) &&
             (field(30, 4) == 48'(MY_IP)) && (field(36, 2) == 48'(MY_PORT));
    if (!hdr_ok) begin
      exp_hdr++;
      push_ev(EV_DROP, 0, 8'h0, 0, '0, '0, '0);
      return;
    end
    p  = n - 42;
    nw = (p < MAX_B) ? p : MAX_B;
    for (int i = 0; i < nw; i++) push_ev(EV_WR, i, frm[42+i], 0, '0, '0, '0);
    if (p > MAX_B || p < MIN_B) begin
      exp_len++;
      push_ev(EV_DROP, 0, 8'h0, 0, '0, '0, '0);
    end else if (tuser) begin
      exp_fcs++;
      push_ev(EV_DROP, 0, 8'h0, 0, '0, '0, '0);
    end else begin
      exp_acc++;
      push_ev(EV_READY, 0, 8'h0, p, field(6, 6), field(26, 4), field(34, 2));
    end
  endtask

  task automatic set_good(input int plen);
    f_dmac = MY_MAC; f_smac = {$urandom_range(0, 65535), $urandom()};
    f_etype = 16'h0800; f_b0 = 8'h45; f_proto = 8'd17;
    f_sip = $urandom(); f_dip = MY_IP;
    f_sport = 16'($urandom()); f_dport = MY_PORT; f_plen = plen;
  endtask

  task automatic build();
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(f_dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(f_smac[47-8*i -: 8]);
    frm.push_back(f_etype[15:8]); frm.push_back(f_etype[7:0]);
    frm.push_back(f_b0);
    for (int i = 0; i < 8; i++) frm.push_back(8'($urandom()));
    frm.push_back(f_proto);
    frm.push_back(8'($urandom())); frm.push_back(8'($urandom()));
    for (int i = 0; i < 4; i++) frm.push_back(f_sip[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) frm.push_back(f_dip[31-8*i -: 8]);
    frm.push_back(f_sport[15:8]); frm.push_back(f_sport[7:0]);
    frm.push_back(f_dport[15:8]); frm.push_back(f_dport[7:0]);
    for (int i = 0; i < 4; i++) frm.push_back(8'($urandom()));
    for (int i = 0; i < f_plen; i++) frm.push_back(8'($urandom()));
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last, input logic user);
    bit acc = 1'b0;
    S_TDATA = d; S_TLAST = last; S_TUSER = user; S_TVALID = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge ACLK); acc = S_TREADY;
      @(posedge ACLK); #1;
    end
    S_TVALID = 1'b0; S_TLAST = 1'b0; S_TUSER = 1'b0;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL tready_timeout: beat not accepted within 50 cycles");
    end
  endtask

  task automatic drive_bytes(input int count, input bit with_last, input bit tuser, input int gap_pct);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) begin @(posedge ACLK); #1; end
      drive_beat(frm[i], with_last && (i == count - 1), with_last && (i == count - 1) && tuser);
    end
  endtask

  task automatic send_frame(input bit tuser, input int gap_pct);
    model_frame(tuser);
    drive_bytes(frm.size(), 1'b1, tuser, gap_pct);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(posedge ACLK); #1; k++; end
    repeat (4) begin @(posedge ACLK); #1; end
    check({tag, "_pending_events"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_accept_count"}, 64'(ACCEPT_COUNT), 64'(exp_acc));
    check({tag, "_hdr_drop_count"}, 64'(HDR_DROP_COUNT), 64'(exp_hdr));
    check({tag, "_len_drop_count"}, 64'(LEN_DROP_COUNT), 64'(exp_len));
    check({tag, "_fcs_drop_count"}, 64'(FCS_DROP_COUNT), 64'(exp_fcs));
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge ACLK);
    check({tag, "_frame_len"}, 64'(FRAME_LEN), 64'd0);
    check({tag, "_src_mac"}, 64'(SRC_MAC), 64'd0);
    check({tag, "_src_ip"}, 64'(SRC_IP), 64'd0);
    check({tag, "_src_port"}, 64'(SRC_UDP_PORT), 64'd0);
    check({tag, "_rx_en"}, 64'(RX_EN), 64'd0);
    check({tag, "_frame_ready"}, 64'(FRAME_READY), 64'd0);
    check({tag, "_frame_drop"}, 64'(FRAME_DROP), 64'd0);
    check({tag, "_tready"}, 64'(S_TREADY), 64'd1);
    check_counters(tag);
    @(posedge ACLK); #1;
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [47:0] keep_mac;
    logic [31:0] keep_ip;
    logic [15:0] keep_port;
    int          v;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    check_idle_outputs("reset");

    // Full-size good frame.
    set_good(785); build(); send_frame(1'b0, 0);
    drain("t1"); check_counters("t1");

    // Commit at 100 bytes, then a 63-byte length drop must leave metadata untouched.
    set_good(100); build(); send_frame(1'b0, 10);
    keep_mac = f_smac; keep_ip = f_sip; keep_port = f_sport;
    set_good(63); build(); send_frame(1'b0, 10);
    drain("t2"); check_counters("t2");
    check("t2_len_held", 64'(FRAME_LEN), 64'd100);
    check("t2_mac_held", 64'(SRC_MAC), 64'(keep_mac));
    check("t2_ip_held", 64'(SRC_IP), 64'(keep_ip));
    check("t2_port_held", 64'(SRC_UDP_PORT), 64'(keep_port));

    // Oversize, then recovery.
    set_good(800); build(); send_frame(1'b0, 5);
    set_good(200); build(); send_frame(1'b0, 0);
    drain("t3"); check_counters("t3");

    // Header filtering variants.
    set_good(120); f_dip = MY_IP ^ 32'h1;         build(); send_frame(1'b0, 0);
    set_good(120); f_dmac = 48'hFFFF_FFFF_FFFF;   build(); send_frame(1'b0, 0);
    set_good(120); f_dport = MY_PORT + 16'd1;     build(); send_frame(1'b0, 0);
    set_good(120); f_dmac = MY_MAC ^ 48'h100;     build(); send_frame(1'b0, 0);
    set_good(120); f_etype = 16'h86DD;            build(); send_frame(1'b0, 0);
    set_good(120); f_proto = 8'd6;                build(); send_frame(1'b0, 0);
    set_good(120); f_b0 = 8'h46;                  build(); send_frame(1'b0, 0);
    drain("t4"); check_counters("t4");

    // TLAST inside the IP header, then a back-to-back frame with random gaps.
    set_good(300); build();
    while (frm.size() > 21) void'(frm.pop_back());
    send_frame(1'b0, 0);
    set_good(300); build(); send_frame(1'b0, 40);
    drain("t5"); check_counters("t5");

    // FCS error and length boundaries.
    set_good(300); build(); send_frame(1'b1, 0);
    set_good(0);   build(); send_frame(1'b0, 0);
    set_good(1);   build(); send_frame(1'b0, 0);
    set_good(MIN_B); build(); send_frame(1'b0, 0);
    set_good(MAX_B); build(); send_frame(1'b1, 0);
    set_good(MAX_B + 1); build(); send_frame(1'b0, 0);
    set_good(MIN_B - 1); build(); send_frame(1'b1, 0);
    drain("t6"); check_counters("t6");

    // Randomised mix, back to back.
    for (int n = 0; n < 24; n++) begin
      set_good($urandom_range(1, 820));
      v = $urandom_range(0, 9);
      case (v)
        0: f_dip = $urandom();
        1: f_dmac = {$urandom_range(0, 65535), $urandom()};
        2: f_dmac = 48'hFFFF_FFFF_FFFF;
        3: f_dport = 16'($urandom());
        default: ;
      endcase
      build();
      if (v == 4) while (frm.size() > $urandom_range(1, 42)) void'(frm.pop_back());
      send_frame($urandom_range(0, 4) == 0, 20);
    end
    drain("rand"); check_counters("rand");

    // Reset in the middle of a payload.
    set_good(300); build();
    for (int i = 0; i < 100; i++) push_ev(EV_WR, i, frm[42+i], 0, '0, '0, '0);
    drive_bytes(142, 1'b0, 1'b0, 10);
    drain("mid_rst_writes");
    ARESET = 1'b1;
    repeat (2) begin @(posedge ACLK); #1; end
    ARESET = 1'b0;
    exp_acc = 0; exp_hdr = 0; exp_len = 0; exp_fcs = 0;
    check_idle_outputs("mid_rst");
    set_good(150); build(); send_frame(1'b0, 10);
    drain("post_rst"); check_counters("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
